// File: rtl/shifter_arbiter_pkg.sv
// Shared definitions for the shifter arbiter: FSM states and width helper.
package shifter_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Index width for a field of n entries; never narrower than one bit.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shifter_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker
  import shifter_arbiter_pkg::*;
#(
  parameter  int R  = 4,
  localparam int PW = cw_of(R)
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [PW-1:0] idx
);

  always_comb begin : pick
    logic found;
    int   j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < R; i++) begin
      j = int'(ptr) + i;
      if (j >= R) j = j - R;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin front end that shares one Shifter between R requesters and
// returns each result with a one-hot done pulse.
module shifter_arbiter
  import shifter_arbiter_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int R  = 4,
  localparam int CW = cw_of(N),
  localparam int PW = cw_of(R)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [R-1:0]  i_req,
  input  logic [R*N-1:0]  i_value,
  input  logic [R-1:0]  i_direction,
  input  logic [R-1:0]  i_rotate,
  input  logic [R*CW-1:0] i_amount,
  output logic [R-1:0]  o_grant,
  output logic [R-1:0]  o_done,
  output logic [N-1:0]  o_result,
  output logic          o_busy,
  output logic          o_sh_start,
  output logic          o_sh_direction,
  output logic          o_sh_rotate,
  output logic [N-1:0]  o_sh_value,
  input  logic [N-1:0]  i_sh_value,
  input  logic          i_sh_finished
);

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [R-1:0]  win_q, win_d;
  logic [N-1:0]  val_q, val_d;
  logic          dir_q, dir_d;
  logic          rot_q, rot_d;
  logic [CW-1:0] amt_q, amt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin_seen_q, fin_seen_d;
  logic [N-1:0]  result_q, result_d;
  logic [R-1:0]  done_q, done_d;

  logic [R-1:0]  pick_grant;
  logic [PW-1:0] pick_idx;

  rr_picker #(.R(R)) u_picker (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    val_d      = val_q;
    dir_d      = dir_q;
    rot_d      = rot_q;
    amt_d      = amt_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = '0;
    // A finish pulse can land before DRAIN (amount N-1); remember it.
    fin_seen_d = (state_q == ST_IDLE) ? 1'b0 : (fin_seen_q | i_sh_finished);

    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          win_d   = pick_grant;
          val_d   = i_value[int'(pick_idx)*N +: N];
          dir_d   = i_direction[pick_idx];
          rot_d   = i_rotate[pick_idx];
          amt_d   = i_amount[int'(pick_idx)*CW +: CW];
          ptr_d   = (int'(pick_idx) == R-1) ? '0 : pick_idx + PW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = amt_q;
        state_d = (amt_q == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d = i_sh_value;
        done_d   = win_q;
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fin_seen_q | i_sh_finished) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      val_q      <= '0;
      dir_q      <= 1'b0;
      rot_q      <= 1'b0;
      amt_q      <= '0;
      cnt_q      <= '0;
      fin_seen_q <= 1'b0;
      result_q   <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      val_q      <= val_d;
      dir_q      <= dir_d;
      rot_q      <= rot_d;
      amt_q      <= amt_d;
      cnt_q      <= cnt_d;
      fin_seen_q <= fin_seen_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign o_busy         = (state_q != ST_IDLE);
  assign o_sh_start     = (state_q == ST_LOAD);
  assign o_grant        = (state_q == ST_LOAD) ? win_q : '0;
  assign o_done         = done_q;
  assign o_result       = result_q;
  // Shifter controls only carry the latched fields while an operation is live.
  assign o_sh_direction = o_busy & dir_q;
  assign o_sh_rotate    = o_busy & rot_q;
  assign o_sh_value     = o_busy ? val_q : '0;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter with a behavioural Shifter attached.
module tb_shifter_arbiter;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [R-1:0]    req, dirv, rotv;
  logic [R*N-1:0]  val;
  logic [R*CW-1:0] amt;
  logic [R-1:0]    grant, done;
  logic [N-1:0]    result, sh_value, sh_q;
  logic            busy, sh_start, sh_dir, sh_rot, sh_fin;

  shifter_arbiter #(.N(N), .R(R)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_value(val),
    .i_direction(dirv), .i_rotate(rotv), .i_amount(amt),
    .o_grant(grant), .o_done(done), .o_result(result), .o_busy(busy),
    .o_sh_start(sh_start), .o_sh_direction(sh_dir), .o_sh_rotate(sh_rot),
    .o_sh_value(sh_value), .i_sh_value(sh_q), .i_sh_finished(sh_fin)
  );

  // Attached Shifter: loads on start, moves one bit per cycle, finishes after N steps.
  int sh_step;
  bit sh_act;
  assign sh_fin = sh_act && (sh_step == N-1);

  function automatic logic [N-1:0] shift1(input logic [N-1:0] q, input bit d, input bit r);
    if (d) return r ? {q[N-2:0], q[N-1]} : {q[N-2:0], 1'b0};
    else   return r ? {q[0], q[N-1:1]}   : {1'b0, q[N-1:1]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sh_q <= '0; sh_act <= 1'b0; sh_step <= 0;
    end else if (sh_start) begin
      sh_q <= sh_value; sh_act <= 1'b1; sh_step <= 0;
    end else if (sh_act) begin
      sh_q    <= shift1(sh_q, sh_dir, sh_rot);
      sh_step <= sh_step + 1;
      if (sh_step == N-1) sh_act <= 1'b0;
    end
  end

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Whole-amount shift computed arithmetically.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] v, input bit d, input bit r, input int a);
    int x, y;
    x = int'(v);
    if (d) y = r ? ((x << a) | (x >> (N - a))) : (x << a);
    else   y = r ? ((x >> a) | (x << (N - a))) : (x >> a);
    return N'(y & ((1 << N) - 1));
  endfunction

  // Transaction-level model: an accepted request at IDLE cycle s grants at s+1,
  // reports at s+A+3 and frees the arbiter at s+max(N+2, A+4).
  bit           op_act = 1'b0;
  int           m_s, m_e, m_a, m_w, ptr_m = 0;
  logic [N-1:0] m_v, exp_res = '0;
  bit           m_d, m_r;
  int           g_cyc[$], g_idx[$];

  task automatic model_step();
    logic [31:0] e_grant, e_done;
    bit e_busy;
    if (op_act && cyc >= m_e) op_act = 1'b0;
    e_busy  = op_act && (cyc > m_s);
    e_grant = (op_act && cyc == m_s + 1) ? (32'd1 << m_w) : 32'd0;
    e_done  = (op_act && cyc == m_s + m_a + 3) ? (32'd1 << m_w) : 32'd0;
    if (e_done != 0) exp_res = ref_shift(m_v, m_d, m_r, m_a);
    chk("busy", busy, e_busy);
    chk("grant", grant, e_grant);
    chk("sh_start", sh_start, e_grant != 0);
    chk("done", done, e_done);
    chk("result", result, exp_res);
    chk("sh_dir", sh_dir, e_busy & m_d);
    chk("sh_rot", sh_rot, e_busy & m_r);
    chk("sh_value", sh_value, e_busy ? m_v : '0);
    if (rst) begin
      op_act = 1'b0; ptr_m = 0; exp_res = '0;
    end else if (!op_act && req != 0) begin
      for (int k = 0; k < R; k++) begin
        int idx;
        idx = (ptr_m + k) % R;
        if (req[idx]) begin m_w = idx; break; end
      end
      m_s = cyc; m_a = int'(amt[m_w*CW +: CW]);
      m_v = val[m_w*N +: N]; m_d = dirv[m_w]; m_r = rotv[m_w];
      m_e = cyc + ((m_a + 4 > N + 2) ? m_a + 4 : N + 2);
      ptr_m = (m_w + 1) % R; op_act = 1'b1;
    end
  endtask

  logic            d_rst = 1'b1;
  logic [R-1:0]    d_req = '0, d_dir = '0, d_rot = '0;
  logic [R*N-1:0]  d_val = '0;
  logic [R*CW-1:0] d_amt = '0;

  initial begin
    rst = 1'b1; req = '0; val = '0; dirv = '0; rotv = '0; amt = '0;
  end

  task automatic tick();
    cyc++;
    @(posedge clk);
    #1;
    rst = d_rst; req = d_req; val = d_val; dirv = d_dir; rotv = d_rot; amt = d_amt;
    @(negedge clk);
    model_step();
    for (int k = 0; k < R; k++)
      if (grant[k]) begin g_cyc.push_back(cyc); g_idx.push_back(k); end
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_req = '0; tick(); tick(); d_rst = 1'b0;
  endtask

  task automatic run_one(input string tag, input int k, input logic [N-1:0] v,
                         input bit d, input bit r, input int a, input logic [N-1:0] exp);
    int t0, got_c;
    d_val = {$urandom, $urandom}; d_amt = $urandom; d_dir = $urandom; d_rot = $urandom;
    d_val[k*N +: N] = v; d_amt[k*CW +: CW] = CW'(a); d_dir[k] = d; d_rot[k] = r;
    d_req = '0; d_req[k] = 1'b1;
    t0 = cyc + 1;
    tick();
    d_req = '0; d_val = {$urandom, $urandom};
    got_c = -1;
    for (int i = 0; i < 20 && got_c < 0; i++) begin
      tick();
      if (done != 0) got_c = cyc;
    end
    chk({tag, "_latency"}, got_c - t0, a + 3);
    chk({tag, "_done"}, done, 32'd1 << k);
    chk({tag, "_result"}, result, exp);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int odd;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    d_rst = 1'b0;

    run_one("t1", 0, 8'h96, 1'b1, 1'b0, 3, 8'hB0);
    run_one("t2", 1, 8'h81, 1'b0, 1'b1, 1, 8'hC0);
    run_one("t3", 3, 8'h5A, 1'b0, 1'b0, 0, 8'h5A);
    run_one("max_amt", 2, 8'hC3, 1'b1, 1'b1, N-1, 8'hE1);

    // All four requesting after reset: strict rotation, LOAD cycles N+2 apart.
    do_reset();
    d_amt = {R{3'd2}}; d_req = '1; g_cyc.delete(); g_idx.delete();
    repeat (42) tick();
    d_req = '0;
    repeat (15) tick();
    chk("t4_count", g_idx.size() >= 4, 1);
    if (g_idx.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("t4_order", g_idx[i], i);
        if (i > 0) chk("t4_spacing", g_cyc[i] - g_cyc[i-1], N + 2);
      end

    // Two held requesters alternate; the idle ones are never granted.
    do_reset();
    d_req = 4'b0101; g_cyc.delete(); g_idx.delete();
    repeat (45) tick();
    d_req = '0;
    repeat (15) tick();
    odd = 0;
    foreach (g_idx[i]) if (g_idx[i] % 2 == 1) odd++;
    chk("t5_odd_grants", odd, 0);
    chk("t5_count", g_idx.size() >= 4, 1);
    if (g_idx.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t5_order", g_idx[i], (i % 2) * 2);

    // Reset in the middle of an A=5 operation aborts it without a done.
    do_reset();
    d_amt[0 +: CW] = 3'd5; d_req = 4'b0001;
    tick();
    d_req = '0;
    tick(); tick();
    d_rst = 1'b1; tick(); d_rst = 1'b0;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_result", result, 0);
    chk("t6_done", done, 0);
    d_req = 4'b0100;
    tick();
    d_req = '0;
    tick();
    chk("t6_grant", grant, 4'b0100);
    repeat (15) tick();

    // Random traffic with occasional resets and operands changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      d_rst = ($urandom_range(0, 299) == 0);
      d_req = R'($urandom_range(0, 15) & $urandom_range(0, 15));
      d_val = {$urandom, $urandom};
      d_amt = R*CW'($urandom);
      d_dir = R'($urandom);
      d_rot = R'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
